mc_alu_sequencer: RTL and testbench
===================================

// Module: mc_alu_sequencer
// PURPOSE
//  Multi-cycle control FSM that sequences the shared ALU, register file, PC/IR and a unified
//  instruction/data memory port for the MIPS core. Decodes opcode/funct, emits per-state datapath
//  controls and the 4-bit ALU function code (same encoding as the core ALU), and handshakes with
//  memory via req/ack. A watchdog traps a stalled memory into a sticky FAULT state.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles a memory state waits for i_mem_ack before FAULT; 0 = never time out
// PORTS
//  i_clk          in   1  rising-edge clock
//  i_rst_n        in   1  asynchronous active-low reset
//  i_opcode       in   6  IR[31:26], valid from DECODE onward
//  i_funct        in   6  IR[5:0]
//  i_zero         in   1  ALU zero flag, same-cycle combinational
//  i_mem_ack      in   1  memory completes the current request this cycle
//  o_mem_req      out  1  memory request, held until ack
//  o_mem_we       out  1  1 = write (SW), 0 = read
//  o_iord         out  1  address mux: 0 = PC, 1 = ALUOut
//  o_ir_we        out  1  load IR from read data
//  o_pc_we        out  1  load PC
//  o_pc_src       out  2  00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28],IR[25:0],2'b00}
//  o_alu_src_a    out  1  0 = PC, 1 = reg A
//  o_alu_src_b    out  2  00 = reg B, 01 = 4, 10 = ext imm16, 11 = sext imm16 << 2
//  o_alu_func     out  4  ALU function code
//  o_reg_we       out  1  register file write
//  o_reg_dst      out  1  0 = rt, 1 = rd
//  o_mem_to_reg   out  1  0 = ALUOut, 1 = memory data register
//  o_fault        out  1  sticky trap: illegal instruction or memory timeout
//  o_state        out  4  current state encoding, for debug/bench
// BEHAVIOUR
//  ALU codes: ADD 1000, SUB 1001, AND 1100, OR 1101, NOR 1110, XOR 1111, SLL 0000, SRL 0001,
//   SRA 0010, SLT 0100. Default is 1000 in states not listed below.
//  Outputs: Moore decode of the state, except the ack-qualified strobes noted. All strobes not
//   listed for a state are 0.
//  Reset (async, i_rst_n = 0): state = IDLE (0). All strobes 0, o_fault = 0, o_alu_func = 1000,
//   watchdog = 0. Reset mid-request drops o_mem_req immediately.
//  States (encoding) and transitions:
//   IDLE(0): no outputs; -> FETCH after one cycle.
//   FETCH(1): req, iord = 0, src_a = 0, src_b = 01, ADD. In the ack cycle: ir_we = 1, pc_we = 1,
//    pc_src = 00; -> DECODE.
//   DECODE(2): src_a = 0, src_b = 11, ADD (branch target into ALUOut). Next state by opcode:
//    000000 + funct in {20,22,24,25,26,27,2A,00,02,03}h -> EXEC_R
//    08/0C/0D/0E/0A -> EXEC_I; 23/2B -> MEM_ADDR; 04/05 -> BRANCH; 02 -> JUMP; otherwise -> FAULT.
//   EXEC_R(3): src_a = 1, src_b = 00, func from funct (ADD/SUB/AND/OR/XOR/NOR/SLT/SLL/SRL/SRA);
//    -> ALU_WB.
//   EXEC_I(4): src_a = 1, src_b = 10, func: ADDI ADD, ANDI AND, ORI OR, XORI XOR, SLTI SLT;
//    -> ALU_WB.
//   ALU_WB(5): reg_we = 1, mem_to_reg = 0, reg_dst = 1 if opcode == 0, else 0; -> FETCH.
//   MEM_ADDR(6): src_a = 1, src_b = 10, ADD; -> MEM_RD (LW) or MEM_WR (SW).
//   MEM_RD(7): req, iord = 1, we = 0; on ack -> MEM_WB.
//   MEM_WB(8): reg_we = 1, mem_to_reg = 1, reg_dst = 0; -> FETCH.
//   MEM_WR(9): req, iord = 1, we = 1; on ack -> FETCH.
//   BRANCH(10): src_a = 1, src_b = 00, SUB, pc_src = 01;
//    pc_we = (op == 04 & i_zero) | (op == 05 & ~i_zero); -> FETCH.
//   JUMP(11): pc_src = 10, pc_we = 1; -> FETCH.
//   FAULT(15): o_fault = 1, all strobes 0; only reset exits.
//  Handshake: req, we and iord stay constant from assertion until the ack cycle, inclusive.
//   Ack in the first req cycle is legal, so a zero-wait state lasts 1 cycle. Ack while req = 0
//   is ignored.
//  Watchdog: cleared on entry to FETCH/MEM_RD/MEM_WR; increments each waiting cycle without ack.
//   If it reaches MEM_TIMEOUT with no ack -> FAULT and req drops. Ack in the same cycle as the
//   limit wins (normal advance).
//  Latency with zero-wait memory: R/I-type 4, LW 5, SW 4, BEQ/BNE 3, J 3 cycles.
// TESTING
//  1. Reset, ack tied 1, ADD (op 00, funct 20): states 0,1,2,3,5,1; alu_func 1000 in EXEC_R;
//     reg_we = 1 and reg_dst = 1 in ALU_WB only.
//  2. LW (op 23), ack delayed 3 cycles in MEM_RD: req/iord = 1 held 4 cycles, then MEM_WB with
//     mem_to_reg = 1.
//  3. BEQ with i_zero = 1 gives pc_we = 1, pc_src = 01. BNE with i_zero = 1 gives pc_we = 0.
//     Both return to FETCH.
//  4. Illegal op 3F, or funct 01 with op 00: DECODE -> FAULT, o_fault = 1, strobes 0 until
//     i_rst_n = 0.
//  5. MEM_TIMEOUT = 4, ack never asserted: FETCH for 4 cycles then FAULT. Repeat with ack on
//     cycle 4: DECODE, no fault.
//  6. Assert i_rst_n = 0 mid MEM_WR wait: o_mem_req falls asynchronously. After release:
//     IDLE, then FETCH.

Source files
------------

// File: rtl/mc_alu_sequencer.sv
// mc_alu_sequencer
//   Multi-cycle control FSM for the MIPS core. It sequences the shared ALU,
//   register file, PC/IR and the unified instruction/data memory port. It
//   decodes opcode/funct, drives Moore datapath controls per state (the only
//   exceptions are the IR/PC load strobes in FETCH, which are qualified by
//   ack), and handshakes with memory via req/ack. A watchdog traps a stalled
//   memory into a sticky FAULT state.
//
// Parameters
//   MEM_TIMEOUT   cycles a memory state waits for ack before FAULT (0 = never)
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_opcode, i_funct     IR[31:26], IR[5:0]
//   i_zero                ALU zero flag (same-cycle)
//   i_mem_ack             memory completes the current request
//   o_mem_req/o_mem_we    memory request / write enable
//   o_iord                address mux (0 = PC, 1 = ALUOut)
//   o_ir_we, o_pc_we      IR / PC load strobes
//   o_pc_src              00 ALU result, 01 ALUOut, 10 jump target
//   o_alu_src_a/_b        ALU operand selects
//   o_alu_func            4-bit ALU function code
//   o_reg_we/o_reg_dst    register write / destination select (1 = rd)
//   o_mem_to_reg          writeback source (1 = memory data register)
//   o_fault               sticky trap (illegal instruction or memory timeout)
//   o_state               current state encoding
module mc_alu_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_zero,
    input  logic       i_mem_ack,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_iord,
    output logic       o_ir_we,
    output logic       o_pc_we,
    output logic [1:0] o_pc_src,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [3:0] o_alu_func,
    output logic       o_reg_we,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_fault,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        EXEC_I   = 4'd4,
        ALU_WB   = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        MEM_WB   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        FAULT    = 4'd15
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b1000;
    localparam logic [3:0] ALU_SUB = 4'b1001;
    localparam logic [3:0] ALU_AND = 4'b1100;
    localparam logic [3:0] ALU_OR  = 4'b1101;
    localparam logic [3:0] ALU_NOR = 4'b1110;
    localparam logic [3:0] ALU_XOR = 4'b1111;
    localparam logic [3:0] ALU_SLL = 4'b0000;
    localparam logic [3:0] ALU_SRL = 4'b0001;
    localparam logic [3:0] ALU_SRA = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // The counter only ever reaches MEM_TIMEOUT-1 before a trap or a state change.
    localparam int unsigned WD_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t          state;
    state_t          state_nx;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;
    logic            mem_wait;
    logic            r_legal;
    logic [3:0]      r_func;
    logic [3:0]      i_func;

    assign o_state = state;

    // Funct decode for R-type instructions; r_legal gates DECODE -> EXEC_R.
    always_comb begin
        r_legal = 1'b1;
        r_func  = ALU_ADD;
        case (i_funct)
            6'h20:   r_func = ALU_ADD;
            6'h22:   r_func = ALU_SUB;
            6'h24:   r_func = ALU_AND;
            6'h25:   r_func = ALU_OR;
            6'h26:   r_func = ALU_XOR;
            6'h27:   r_func = ALU_NOR;
            6'h2A:   r_func = ALU_SLT;
            6'h00:   r_func = ALU_SLL;
            6'h02:   r_func = ALU_SRL;
            6'h03:   r_func = ALU_SRA;
            default: r_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (i_opcode)
            OP_ADDI: i_func = ALU_ADD;
            OP_ANDI: i_func = ALU_AND;
            OP_ORI:  i_func = ALU_OR;
            OP_XORI: i_func = ALU_XOR;
            OP_SLTI: i_func = ALU_SLT;
            default: i_func = ALU_ADD;
        endcase
    end

    // The limit cycle is the MEM_TIMEOUT-th waiting cycle; an ack in that same
    // cycle takes priority because the ack branches are tested first below.
    assign wd_expired = (MEM_TIMEOUT != 0) && (32'(wd_cnt) == MEM_TIMEOUT - 1);
    assign mem_wait   = o_mem_req && !i_mem_ack && (MEM_TIMEOUT != 0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Any state change clears the count, which covers entry to every memory state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_cnt <= '0;
        end else if (state_nx != state) begin
            wd_cnt <= '0;
        end else if (mem_wait) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    always_comb begin
        state_nx     = state;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_iord       = 1'b0;
        o_ir_we      = 1'b0;
        o_pc_we      = 1'b0;
        o_pc_src     = 2'b00;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = 2'b00;
        o_alu_func   = ALU_ADD;
        o_reg_we     = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_fault      = 1'b0;

        case (state)
            IDLE: begin
                state_nx = FETCH;
            end

            FETCH: begin
                o_mem_req   = 1'b1;
                o_alu_src_b = 2'b01;
                if (i_mem_ack) begin
                    o_ir_we  = 1'b1;
                    o_pc_we  = 1'b1;
                    state_nx = DECODE;
                end else if (wd_expired) begin
                    state_nx = FAULT;
                end
            end

            DECODE: begin
                o_alu_src_b = 2'b11;
                case (i_opcode)
                    OP_RTYPE:                                 state_nx = r_legal ? EXEC_R : FAULT;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: state_nx = EXEC_I;
                    OP_LW, OP_SW:                             state_nx = MEM_ADDR;
                    OP_BEQ, OP_BNE:                           state_nx = BRANCH;
                    OP_J:                                     state_nx = JUMP;
                    default:                                  state_nx = FAULT;
                endcase
            end

            EXEC_R: begin
                o_alu_src_a = 1'b1;
                o_alu_func  = r_func;
                state_nx    = ALU_WB;
            end

            EXEC_I: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                o_alu_func  = i_func;
                state_nx    = ALU_WB;
            end

            ALU_WB: begin
                o_reg_we  = 1'b1;
                o_reg_dst = (i_opcode == OP_RTYPE);
                state_nx  = FETCH;
            end

            MEM_ADDR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                state_nx    = (i_opcode == OP_LW) ? MEM_RD : MEM_WR;
            end

            MEM_RD: begin
                o_mem_req = 1'b1;
                o_iord    = 1'b1;
                if (i_mem_ack) begin
                    state_nx = MEM_WB;
                end else if (wd_expired) begin
                    state_nx = FAULT;
                end
            end

            MEM_WB: begin
                o_reg_we     = 1'b1;
                o_mem_to_reg = 1'b1;
                state_nx     = FETCH;
            end

            MEM_WR: begin
                o_mem_req = 1'b1;
                o_mem_we  = 1'b1;
                o_iord    = 1'b1;
                if (i_mem_ack) begin
                    state_nx = FETCH;
                end else if (wd_expired) begin
                    state_nx = FAULT;
                end
            end

            BRANCH: begin
                o_alu_src_a = 1'b1;
                o_alu_func  = ALU_SUB;
                o_pc_src    = 2'b01;
                o_pc_we     = ((i_opcode == OP_BEQ) && i_zero) ||
                              ((i_opcode == OP_BNE) && !i_zero);
                state_nx    = FETCH;
            end

            JUMP: begin
                o_pc_src = 2'b10;
                o_pc_we  = 1'b1;
                state_nx = FETCH;
            end

            FAULT: begin
                o_fault = 1'b1;
            end

            default: begin
                state_nx = FAULT;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_alu_sequencer.sv
// Bench for mc_alu_sequencer (MEM_TIMEOUT = 4). Stimulus tasks drive one
// cycle at a time and push the hand-written expected state/controls into a
// queue; a negedge monitor pops one entry per cycle and compares it with the
// DUT. Control vector order:
//   {req, we, iord, ir_we, pc_we, pc_src[1:0], src_a, src_b[1:0],
//    alu_func[3:0], reg_we, reg_dst, mem_to_reg, fault}
module tb_mc_alu_sequencer;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_EXEC_R = 4'd3;
    localparam logic [3:0] S_EXEC_I = 4'd4;
    localparam logic [3:0] S_ALU_WB = 4'd5;
    localparam logic [3:0] S_MADDR  = 4'd6;
    localparam logic [3:0] S_MRD    = 4'd7;
    localparam logic [3:0] S_MWB    = 4'd8;
    localparam logic [3:0] S_MWR    = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_FAULT  = 4'd15;

    localparam logic [17:0] C_IDLE    = 18'b0_0_0_0_0_00_0_00_1000_0_0_0_0;
    localparam logic [17:0] C_FETCH_W = 18'b1_0_0_0_0_00_0_01_1000_0_0_0_0;
    localparam logic [17:0] C_FETCH_A = 18'b1_0_0_1_1_00_0_01_1000_0_0_0_0;
    localparam logic [17:0] C_DECODE  = 18'b0_0_0_0_0_00_0_11_1000_0_0_0_0;
    localparam logic [17:0] C_WB_R    = 18'b0_0_0_0_0_00_0_00_1000_1_1_0_0;
    localparam logic [17:0] C_WB_I    = 18'b0_0_0_0_0_00_0_00_1000_1_0_0_0;
    localparam logic [17:0] C_MADDR   = 18'b0_0_0_0_0_00_1_10_1000_0_0_0_0;
    localparam logic [17:0] C_MRD     = 18'b1_0_1_0_0_00_0_00_1000_0_0_0_0;
    localparam logic [17:0] C_MWB     = 18'b0_0_0_0_0_00_0_00_1000_1_0_1_0;
    localparam logic [17:0] C_MWR     = 18'b1_1_1_0_0_00_0_00_1000_0_0_0_0;
    localparam logic [17:0] C_BR_T    = 18'b0_0_0_0_1_01_1_00_1001_0_0_0_0;
    localparam logic [17:0] C_BR_N    = 18'b0_0_0_0_0_01_1_00_1001_0_0_0_0;
    localparam logic [17:0] C_JUMP    = 18'b0_0_0_0_1_10_0_00_1000_0_0_0_0;
    localparam logic [17:0] C_FAULT   = 18'b0_0_0_0_0_00_0_00_1000_0_0_0_1;

    logic       i_clk;
    logic       i_rst_n;
    logic [5:0] i_opcode;
    logic [5:0] i_funct;
    logic       i_zero;
    logic       i_mem_ack;
    logic       o_mem_req;
    logic       o_mem_we;
    logic       o_iord;
    logic       o_ir_we;
    logic       o_pc_we;
    logic [1:0] o_pc_src;
    logic       o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic [3:0] o_alu_func;
    logic       o_reg_we;
    logic       o_reg_dst;
    logic       o_mem_to_reg;
    logic       o_fault;
    logic [3:0] o_state;

    logic [17:0] act_ctl;

    typedef struct {
        logic [3:0]  st;
        logic [17:0] ctl;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk;
    int   n_fail;

    mc_alu_sequencer #(.MEM_TIMEOUT(4)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_opcode     (i_opcode),
        .i_funct      (i_funct),
        .i_zero       (i_zero),
        .i_mem_ack    (i_mem_ack),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_iord       (o_iord),
        .o_ir_we      (o_ir_we),
        .o_pc_we      (o_pc_we),
        .o_pc_src     (o_pc_src),
        .o_alu_src_a  (o_alu_src_a),
        .o_alu_src_b  (o_alu_src_b),
        .o_alu_func   (o_alu_func),
        .o_reg_we     (o_reg_we),
        .o_reg_dst    (o_reg_dst),
        .o_mem_to_reg (o_mem_to_reg),
        .o_fault      (o_fault),
        .o_state      (o_state)
    );

    assign act_ctl = {o_mem_req, o_mem_we, o_iord, o_ir_we, o_pc_we, o_pc_src,
                      o_alu_src_a, o_alu_src_b, o_alu_func,
                      o_reg_we, o_reg_dst, o_mem_to_reg, o_fault};

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Monitor: one expected entry per cycle, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            n_chk++;
            if (o_state !== mon_e.st || act_ctl !== mon_e.ctl) begin
                n_fail++;
                $display("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
                         mon_e.name, o_state, act_ctl, mon_e.st, mon_e.ctl);
            end
        end
    end

    // One cycle: drive inputs, queue the expectation, advance past the edge.
    task automatic cyc(input logic ack, input logic zero, input logic [3:0] st,
                       input logic [17:0] ctl, input string name);
        exp_t e;
        i_mem_ack = ack;
        i_zero    = zero;
        e.st      = st;
        e.ctl     = ctl;
        e.name    = name;
        q.push_back(e);
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        cyc(1'b0, 1'b0, S_IDLE, C_IDLE, "reset_held");
        cyc(1'b0, 1'b0, S_IDLE, C_IDLE, "reset_held2");
        i_rst_n = 1'b1;
        cyc(1'b0, 1'b0, S_IDLE, C_IDLE, "idle_after_release");
    endtask

    // FETCH with optional wait cycles, then DECODE (ack high there must be ignored).
    task automatic fetch(input int unsigned waits, input logic [5:0] op, input logic [5:0] fn);
        i_opcode = op;
        i_funct  = fn;
        for (int unsigned k = 0; k < waits; k++)
            cyc(1'b0, 1'b0, S_FETCH, C_FETCH_W, "fetch_wait");
        cyc(1'b1, 1'b0, S_FETCH, C_FETCH_A, "fetch_ack");
        cyc(1'b1, 1'b0, S_DECODE, C_DECODE, "decode");
    endtask

    task automatic r_type(input logic [5:0] fn, input logic [3:0] func, input logic ack);
        fetch(0, 6'h00, fn);
        cyc(ack, 1'b0, S_EXEC_R, {5'b0, 2'b00, 1'b1, 2'b00, func, 4'b0000}, "exec_r");
        cyc(ack, 1'b0, S_ALU_WB, C_WB_R, "alu_wb_r");
    endtask

    task automatic i_type(input logic [5:0] op, input logic [3:0] func);
        fetch(0, op, 6'h00);
        cyc(1'b0, 1'b0, S_EXEC_I, {5'b0, 2'b00, 1'b1, 2'b10, func, 4'b0000}, "exec_i");
        cyc(1'b0, 1'b0, S_ALU_WB, C_WB_I, "alu_wb_i");
    endtask

    task automatic lw(input int unsigned waits);
        fetch(0, 6'h23, 6'h00);
        cyc(1'b0, 1'b0, S_MADDR, C_MADDR, "mem_addr_lw");
        for (int unsigned k = 0; k < waits; k++)
            cyc(1'b0, 1'b0, S_MRD, C_MRD, "mem_rd_wait");
        cyc(1'b1, 1'b0, S_MRD, C_MRD, "mem_rd_ack");
        cyc(1'b0, 1'b0, S_MWB, C_MWB, "mem_wb");
    endtask

    task automatic sw(input int unsigned waits);
        fetch(0, 6'h2B, 6'h00);
        cyc(1'b0, 1'b0, S_MADDR, C_MADDR, "mem_addr_sw");
        for (int unsigned k = 0; k < waits; k++)
            cyc(1'b0, 1'b0, S_MWR, C_MWR, "mem_wr_wait");
        cyc(1'b1, 1'b0, S_MWR, C_MWR, "mem_wr_ack");
    endtask

    task automatic br(input logic [5:0] op, input logic zero, input logic taken);
        fetch(0, op, 6'h00);
        cyc(1'b0, zero, S_BRANCH, taken ? C_BR_T : C_BR_N, "branch");
    endtask

    task automatic jmp(input int unsigned waits);
        fetch(waits, 6'h02, 6'h00);
        cyc(1'b0, 1'b0, S_JUMP, C_JUMP, "jump");
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: bench did not complete within time limit");
        $fatal(1);
    end

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        i_rst_n   = 1'b1;
        i_opcode  = 6'h00;
        i_funct   = 6'h20;
        i_zero    = 1'b0;
        i_mem_ack = 1'b0;
        #2;
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        do_reset();

        // ALU instructions (ADD with ack held high throughout)
        r_type(6'h20, 4'b1000, 1'b1);
        r_type(6'h22, 4'b1001, 1'b0);
        r_type(6'h2A, 4'b0100, 1'b0);
        r_type(6'h03, 4'b0010, 1'b0);
        r_type(6'h27, 4'b1110, 1'b0);
        r_type(6'h00, 4'b0000, 1'b0);
        r_type(6'h02, 4'b0001, 1'b0);
        i_type(6'h0D, 4'b1101);
        i_type(6'h08, 4'b1000);
        i_type(6'h0E, 4'b1111);
        i_type(6'h0A, 4'b0100);

        // Memory: LW with 3 wait cycles, zero-wait LW, SW with one wait
        lw(3);
        lw(0);
        sw(1);

        // Branches and jump (jump preceded by a 2-cycle fetch stall)
        br(6'h04, 1'b1, 1'b1);
        br(6'h05, 1'b1, 1'b0);
        br(6'h05, 1'b0, 1'b1);
        br(6'h04, 1'b0, 1'b0);
        jmp(2);

        // Illegal opcode traps and stays trapped, ack ignored
        fetch(0, 6'h3F, 6'h00);
        cyc(1'b1, 1'b0, S_FAULT, C_FAULT, "fault_illegal_op");
        cyc(1'b1, 1'b1, S_FAULT, C_FAULT, "fault_sticky");
        cyc(1'b0, 1'b0, S_FAULT, C_FAULT, "fault_sticky2");
        do_reset();

        // Illegal funct with R-type opcode
        fetch(0, 6'h00, 6'h01);
        cyc(1'b1, 1'b0, S_FAULT, C_FAULT, "fault_illegal_funct");
        cyc(1'b0, 1'b0, S_FAULT, C_FAULT, "fault_sticky3");
        do_reset();

        // FETCH watchdog: no ack for 4 cycles traps
        i_opcode = 6'h00;
        i_funct  = 6'h20;
        for (int unsigned k = 0; k < 4; k++)
            cyc(1'b0, 1'b0, S_FETCH, C_FETCH_W, "fetch_timeout_wait");
        cyc(1'b0, 1'b0, S_FAULT, C_FAULT, "fault_fetch_timeout");
        cyc(1'b1, 1'b0, S_FAULT, C_FAULT, "fault_fetch_timeout_sticky");
        do_reset();

        // Ack in the limit cycle wins
        r_type_after_waits: begin
            fetch(3, 6'h00, 6'h20);
            cyc(1'b0, 1'b0, S_EXEC_R, {5'b0, 2'b00, 1'b1, 2'b00, 4'b1000, 4'b0000}, "exec_r_after_limit_ack");
            cyc(1'b0, 1'b0, S_ALU_WB, C_WB_R, "alu_wb_after_limit_ack");
        end

        // MEM_RD watchdog
        fetch(0, 6'h23, 6'h00);
        cyc(1'b0, 1'b0, S_MADDR, C_MADDR, "mem_addr_to");
        for (int unsigned k = 0; k < 4; k++)
            cyc(1'b0, 1'b0, S_MRD, C_MRD, "mem_rd_timeout_wait");
        cyc(1'b0, 1'b0, S_FAULT, C_FAULT, "fault_mem_rd_timeout");
        do_reset();

        // Reset during a MEM_WR wait drops the request before the next edge
        fetch(0, 6'h2B, 6'h00);
        cyc(1'b0, 1'b0, S_MADDR, C_MADDR, "mem_addr_sw_rst");
        cyc(1'b0, 1'b0, S_MWR, C_MWR, "mem_wr_wait_rst");
        do_reset();
        jmp(0);

        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
